// File: rtl/lock_pkg.sv
// ----------------------------------------------------------------------------
// lock_pkg
// Shared types and constants for the N-digit keypad lock controller.
//   lock_state_t : controller state, also exported on state_o
//   KEY_*        : keypad codes with a command meaning (0-9 are digits)
//   is_digit()   : true for keypad codes 0..9
// ----------------------------------------------------------------------------
package lock_pkg;

   typedef enum logic [2:0] {
      LOCKED      = 3'd0,
      ENTRY       = 3'd1,
      CHECK       = 3'd2,
      OPEN        = 3'd3,
      SET_NEW     = 3'd4,
      SET_CONFIRM = 3'd5,
      LOCKOUT     = 3'd6
   } lock_state_t;

   localparam logic [3:0] KEY_ENTER  = 4'hA;
   localparam logic [3:0] KEY_CLEAR  = 4'hB;
   localparam logic [3:0] KEY_CHANGE = 4'hC;
   localparam logic [3:0] KEY_LOCK   = 4'hD;

   function automatic logic is_digit(input logic [3:0] key);
      return key <= 4'd9;
   endfunction

endpackage

// File: rtl/lock_down_counter.sv
// ----------------------------------------------------------------------------
// lock_down_counter
// Loadable down counter used as the lock's single timer (relock or lockout).
//   clk    : system clock
//   rst    : synchronous reset, active-low
//   load   : load 'value' into the counter this cycle (loading 0 stops it)
//   value  : load value, number of cycles until expire fires
//   expire : high for the one cycle in which the running count equals 1
// The counter stops at zero and never wraps.
// ----------------------------------------------------------------------------
module lock_down_counter #(
   parameter int unsigned WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load,
   input  logic [WIDTH-1:0] value,
   output logic             expire
);

   logic [WIDTH-1:0] count_reg;

   always_ff @(posedge clk) begin
      if (!rst) begin
         count_reg <= '0;
      end else if (load) begin
         count_reg <= value;
      end else if (count_reg != '0) begin
         count_reg <= count_reg - WIDTH'(1);
      end
   end

   // A value of N loaded at edge E makes expire visible before edge E+N,
   // so the owner acts on exactly the Nth edge after the load.
   assign expire = (count_reg == WIDTH'(1));

endmodule

// File: rtl/digital_lock_fsm_n.sv
// ----------------------------------------------------------------------------
// digital_lock_fsm_n
// N-digit keypad lock controller with retry lockout, idle auto-relock and an
// in-field code change with confirmation.
//
// Ports:
//   clk         : system clock
//   rst         : synchronous reset, active-low
//   key_valid   : single-cycle pulse qualifying key_code
//   key_code    : 0-9 digit, A enter, B clear, C change code, D lock now
//   unlocked    : high in OPEN, SET_NEW, SET_CONFIRM
//   alarm       : high in LOCKOUT
//   entry_count : number of digits held in the entry buffer
//   disp_digits : entry buffer, newest digit in [3:0]
//   fail_count  : consecutive failed attempts
//   state_o     : current lock_state_t
//
// Optional build macro MASTER_CODE_EN adds parameter MASTER_CODE: the master
// code opens the lock from CHECK, and while in LOCKOUT it clears the lockout
// and restores DEFAULT_CODE.
// ----------------------------------------------------------------------------
module digital_lock_fsm_n
   import lock_pkg::*;
#(
   parameter int unsigned              CODE_DIGITS    = 4,
   parameter int unsigned              MAX_TRIES      = 3,
   parameter int unsigned              LOCKOUT_CYCLES = 250_000_000,
   parameter int unsigned              RELOCK_CYCLES  = 500_000_000,
   parameter logic [4*CODE_DIGITS-1:0] DEFAULT_CODE   = 16'h1234
`ifdef MASTER_CODE_EN
   ,
   parameter logic [4*CODE_DIGITS-1:0] MASTER_CODE    = 16'h9999
`endif
) (
   input  logic                               clk,
   input  logic                               rst,
   input  logic                               key_valid,
   input  logic [3:0]                         key_code,
   output logic                               unlocked,
   output logic                               alarm,
   output logic [$clog2(CODE_DIGITS+1)-1:0]   entry_count,
   output logic [4*CODE_DIGITS-1:0]           disp_digits,
   output logic [3:0]                         fail_count,
   output logic [2:0]                         state_o
);

   localparam int unsigned CODE_W    = 4 * CODE_DIGITS;
   localparam int unsigned CNT_W     = $clog2(CODE_DIGITS + 1);
   localparam int unsigned TIMER_MAX = (LOCKOUT_CYCLES > RELOCK_CYCLES) ?
                                       LOCKOUT_CYCLES : RELOCK_CYCLES;
   localparam int unsigned TIMER_W   = $clog2(TIMER_MAX + 1);

   localparam logic [TIMER_W-1:0] RELOCK_LOAD  = TIMER_W'(RELOCK_CYCLES);
   localparam logic [TIMER_W-1:0] LOCKOUT_LOAD = TIMER_W'(LOCKOUT_CYCLES);

   lock_state_t        state_reg, state_next;
   logic [CODE_W-1:0]  buf_reg, buf_next;
   logic [CNT_W-1:0]   count_reg, count_next;
   logic [3:0]         fail_reg, fail_next;
   logic [CODE_W-1:0]  code_reg, code_next;
   logic [CODE_W-1:0]  cand_reg, cand_next;

   logic               timer_load;
   logic [TIMER_W-1:0] timer_value;
   logic               timer_expire;

   logic               digit_key, enter_key, clear_key, change_key, lock_key;
   logic               buf_full, code_match, master_match;
   logic [CODE_W-1:0]  buf_shift;
   logic [CNT_W-1:0]   count_shift;
   logic [3:0]         fail_inc;

   // Relock and lockout never run at the same time, so one counter serves both.
   lock_down_counter #(
      .WIDTH (TIMER_W)
   ) u_timer (
      .clk    (clk),
      .rst    (rst),
      .load   (timer_load),
      .value  (timer_value),
      .expire (timer_expire)
   );

   assign digit_key  = key_valid && is_digit(key_code);
   assign enter_key  = key_valid && (key_code == KEY_ENTER);
   assign clear_key  = key_valid && (key_code == KEY_CLEAR);
   assign change_key = key_valid && (key_code == KEY_CHANGE);
   assign lock_key   = key_valid && (key_code == KEY_LOCK);

   // Once the buffer is full further digits are dropped without shifting.
   assign buf_full    = (count_reg == CNT_W'(CODE_DIGITS));
   assign buf_shift   = buf_full ? buf_reg : ((buf_reg << 4) | CODE_W'(key_code));
   assign count_shift = buf_full ? count_reg : (count_reg + CNT_W'(1));
   assign fail_inc    = fail_reg + 4'd1;
   assign code_match  = buf_full && (buf_reg == code_reg);

`ifdef MASTER_CODE_EN
   assign master_match = buf_full && (buf_reg == MASTER_CODE);
`else
   assign master_match = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_reg <= LOCKED;
         buf_reg   <= '0;
         count_reg <= '0;
         fail_reg  <= '0;
         code_reg  <= DEFAULT_CODE;
         cand_reg  <= '0;
      end else begin
         state_reg <= state_next;
         buf_reg   <= buf_next;
         count_reg <= count_next;
         fail_reg  <= fail_next;
         code_reg  <= code_next;
         cand_reg  <= cand_next;
      end
   end

   always_comb begin
      state_next  = state_reg;
      buf_next    = buf_reg;
      count_next  = count_reg;
      fail_next   = fail_reg;
      code_next   = code_reg;
      cand_next   = cand_reg;
      timer_load  = 1'b0;
      timer_value = '0;

      case (state_reg)
         LOCKED: begin
            if (digit_key) begin
               buf_next   = buf_shift;
               count_next = count_shift;
               state_next = ENTRY;
            end
         end

         ENTRY: begin
            if (digit_key) begin
               buf_next   = buf_shift;
               count_next = count_shift;
            end else if (clear_key) begin
               buf_next   = '0;
               count_next = '0;
               state_next = LOCKED;
            end else if (enter_key) begin
               state_next = CHECK;
            end
         end

         CHECK: begin
            buf_next   = '0;
            count_next = '0;
            if (code_match || master_match) begin
               fail_next   = '0;
               state_next  = OPEN;
               timer_load  = 1'b1;
               timer_value = RELOCK_LOAD;
            end else begin
               fail_next = fail_inc;
               if (fail_inc >= 4'(MAX_TRIES)) begin
                  state_next  = LOCKOUT;
                  timer_load  = 1'b1;
                  timer_value = LOCKOUT_LOAD;
               end else begin
                  state_next = LOCKED;
               end
            end
         end

         OPEN: begin
            // Expiry wins over a key arriving on the same edge.
            if (timer_expire) begin
               state_next = LOCKED;
            end else if (key_valid) begin
               timer_load  = 1'b1;
               timer_value = RELOCK_LOAD;
               if (lock_key) begin
                  timer_value = '0;
                  state_next  = LOCKED;
               end else if (change_key) begin
                  buf_next   = '0;
                  count_next = '0;
                  state_next = SET_NEW;
               end
            end
         end

         SET_NEW, SET_CONFIRM: begin
            // The relock timer keeps running while a new code is being set;
            // any key counts as activity and restarts it.
            if (timer_expire) begin
               buf_next   = '0;
               count_next = '0;
               cand_next  = '0;
               state_next = LOCKED;
            end else if (key_valid) begin
               timer_load  = 1'b1;
               timer_value = RELOCK_LOAD;
               if (digit_key) begin
                  buf_next   = buf_shift;
                  count_next = count_shift;
               end else if (clear_key) begin
                  buf_next   = '0;
                  count_next = '0;
                  cand_next  = '0;
                  state_next = OPEN;
               end else if (enter_key) begin
                  if (state_reg == SET_NEW) begin
                     if (buf_full) begin
                        cand_next  = buf_reg;
                        buf_next   = '0;
                        count_next = '0;
                        state_next = SET_CONFIRM;
                     end
                  end else begin
                     if (buf_full && (buf_reg == cand_reg)) begin
                        code_next = cand_reg;
                     end
                     cand_next  = '0;
                     buf_next   = '0;
                     count_next = '0;
                     state_next = OPEN;
                  end
               end
            end
         end

         LOCKOUT: begin
            if (timer_expire) begin
               fail_next  = '0;
               buf_next   = '0;
               count_next = '0;
               state_next = LOCKED;
            end
`ifdef MASTER_CODE_EN
            else if (digit_key) begin
               buf_next   = buf_shift;
               count_next = count_shift;
            end else if (enter_key) begin
               buf_next   = '0;
               count_next = '0;
               if (master_match) begin
                  fail_next   = '0;
                  code_next   = DEFAULT_CODE;
                  timer_load  = 1'b1;
                  timer_value = '0;
                  state_next  = LOCKED;
               end
            end
`endif
         end

         default: begin
            state_next = LOCKED;
         end
      endcase
   end

   assign unlocked    = (state_reg == OPEN) || (state_reg == SET_NEW) ||
                        (state_reg == SET_CONFIRM);
   assign alarm       = (state_reg == LOCKOUT);
   assign entry_count = count_reg;
   assign disp_digits = buf_reg;
   assign fail_count  = fail_reg;
   assign state_o     = state_reg;

endmodule

// File: tb/tb_digital_lock_fsm_n.sv
// ----------------------------------------------------------------------------
// tb_digital_lock_fsm_n
// Self-checking bench for digital_lock_fsm_n with short timers. Directed
// scenario tasks check fixed expectations; a randomized task compares every
// cycle against a reference model that keeps the entry as a digit queue, the
// code as a digit array and timers as absolute deadline cycle numbers.
// ----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_digital_lock_fsm_n;
   import lock_pkg::*;

   localparam int CD = 4;
   localparam int MT = 3;
   localparam int LC = 20;
   localparam int RC = 10;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        key_valid = 1'b0;
   logic [3:0]  key_code = 4'h0;
   logic        unlocked, alarm;
   logic [2:0]  entry_count;
   logic [15:0] disp_digits;
   logic [3:0]  fail_count;
   logic [2:0]  state_o;

   int checks = 0;
   int failures = 0;

   // reference model
   lock_state_t m_state = LOCKED;
   int          m_buf[$];
   int          m_code[4] = '{1, 2, 3, 4};
   int          m_cand[4] = '{0, 0, 0, 0};
   int          m_fail = 0;
   longint      cyc = 0;
   longint      m_deadline = -1;

   always #5 clk = ~clk;

   digital_lock_fsm_n #(
      .CODE_DIGITS    (CD),
      .MAX_TRIES      (MT),
      .LOCKOUT_CYCLES (LC),
      .RELOCK_CYCLES  (RC),
      .DEFAULT_CODE   (16'h1234)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .key_valid   (key_valid),
      .key_code    (key_code),
      .unlocked    (unlocked),
      .alarm       (alarm),
      .entry_count (entry_count),
      .disp_digits (disp_digits),
      .fail_count  (fail_count),
      .state_o     (state_o)
   );

   function automatic bit full_match(input int ref_code[4]);
      if (m_buf.size() != CD) return 1'b0;
      for (int i = 0; i < CD; i++) if (m_buf[i] != ref_code[i]) return 1'b0;
      return 1'b1;
   endfunction

   function automatic logic [15:0] disp_of();
      int v = 0;
      foreach (m_buf[i]) v = v * 16 + m_buf[i];
      return 16'(v);
   endfunction

   task automatic add_digit(input int d);
      if (m_buf.size() < CD) m_buf.push_back(d);
   endtask

   // Applies the lock rules for one clock edge.
   task automatic model_step(input logic v, input logic [3:0] k);
      bit exp_now, dig;
      int kk;
      cyc++;
      if (!rst) begin
         m_state = LOCKED; m_buf.delete(); m_code = '{1, 2, 3, 4};
         m_cand = '{0, 0, 0, 0}; m_fail = 0; m_deadline = -1;
         return;
      end
      exp_now = (cyc == m_deadline);
      kk = int'(k);
      dig = v && (kk <= 9);
      case (m_state)
         LOCKED: if (dig) begin add_digit(kk); m_state = ENTRY; end
         ENTRY: begin
            if (dig) add_digit(kk);
            else if (v && kk == 11) begin m_buf.delete(); m_state = LOCKED; end
            else if (v && kk == 10) m_state = CHECK;
         end
         CHECK: begin
            if (full_match(m_code)) begin
               m_fail = 0; m_state = OPEN; m_deadline = cyc + RC;
            end else begin
               m_fail++;
               if (m_fail >= MT) begin m_state = LOCKOUT; m_deadline = cyc + LC; end
               else m_state = LOCKED;
            end
            m_buf.delete();
         end
         OPEN: begin
            if (exp_now) m_state = LOCKED;
            else if (v) begin
               m_deadline = cyc + RC;
               if (kk == 13) m_state = LOCKED;
               else if (kk == 12) begin m_state = SET_NEW; m_buf.delete(); end
            end
         end
         SET_NEW, SET_CONFIRM: begin
            if (exp_now) begin m_state = LOCKED; m_buf.delete(); end
            else if (v) begin
               m_deadline = cyc + RC;
               if (dig) add_digit(kk);
               else if (kk == 11) begin m_state = OPEN; m_buf.delete(); end
               else if (kk == 10) begin
                  if (m_state == SET_NEW) begin
                     if (m_buf.size() == CD) begin
                        for (int i = 0; i < CD; i++) m_cand[i] = m_buf[i];
                        m_buf.delete(); m_state = SET_CONFIRM;
                     end
                  end else begin
                     if (full_match(m_cand)) m_code = m_cand;
                     m_buf.delete(); m_state = OPEN;
                  end
               end
            end
         end
         LOCKOUT: if (exp_now) begin m_state = LOCKED; m_fail = 0; end
         default: m_state = LOCKED;
      endcase
   endtask

   task automatic press(input logic v, input logic [3:0] k);
      key_valid = v;
      key_code  = k;
      @(posedge clk);
      model_step(v, k);
      #1;
      key_valid = 1'b0;
      key_code  = 4'h0;
      if (v) $display("key=%h rst=%0b state=%0d unlocked=%0b alarm=%0b cnt=%0d disp=%h fails=%0d",
                      k, rst, state_o, unlocked, alarm, entry_count, disp_digits, fail_count);
   endtask

   task automatic key(input logic [3:0] k);
      press(1'b1, k);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) press(1'b0, 4'h0);
   endtask

   task automatic test_reset();
      rst = 1'b0;
      idle(2);
      checks++; if (state_o !== 3'd0) begin failures++; $display("FAIL reset_state: got %0d expected 0", state_o); end
      checks++; if (unlocked !== 1'b0) begin failures++; $display("FAIL reset_unlocked: got %0b expected 0", unlocked); end
      checks++; if (alarm !== 1'b0) begin failures++; $display("FAIL reset_alarm: got %0b expected 0", alarm); end
      checks++; if (entry_count !== 3'd0) begin failures++; $display("FAIL reset_count: got %0d expected 0", entry_count); end
      checks++; if (disp_digits !== 16'h0) begin failures++; $display("FAIL reset_disp: got %h expected 0000", disp_digits); end
      checks++; if (fail_count !== 4'd0) begin failures++; $display("FAIL reset_fails: got %0d expected 0", fail_count); end
      rst = 1'b1;
      idle(1);
   endtask

   task automatic test_unlock();
      key(4'h1); key(4'h2); key(4'h3); key(4'h4);
      checks++; if (disp_digits !== 16'h1234) begin failures++; $display("FAIL unlock_disp: got %h expected 1234", disp_digits); end
      checks++; if (entry_count !== 3'd4) begin failures++; $display("FAIL unlock_count: got %0d expected 4", entry_count); end
      key(KEY_ENTER);
      checks++; if (state_o !== 3'd2) begin failures++; $display("FAIL unlock_check_state: got %0d expected 2", state_o); end
      checks++; if (unlocked !== 1'b0) begin failures++; $display("FAIL unlock_early: got %0b expected 0", unlocked); end
      idle(1);
      checks++; if (unlocked !== 1'b1) begin failures++; $display("FAIL unlock_open: got %0b expected 1", unlocked); end
      checks++; if (fail_count !== 4'd0) begin failures++; $display("FAIL unlock_fails: got %0d expected 0", fail_count); end
      checks++; if (disp_digits !== 16'h0) begin failures++; $display("FAIL unlock_disp_clr: got %h expected 0000", disp_digits); end
      key(KEY_LOCK);
      checks++; if (state_o !== 3'd0) begin failures++; $display("FAIL unlock_lock_now: got %0d expected 0", state_o); end
   endtask

   task automatic test_short_and_saturate();
      key(4'h1); key(4'h2); key(4'h3); key(KEY_ENTER); idle(1);
      checks++; if (state_o !== 3'd0) begin failures++; $display("FAIL short_state: got %0d expected 0", state_o); end
      checks++; if (fail_count !== 4'd1) begin failures++; $display("FAIL short_fails: got %0d expected 1", fail_count); end
      key(4'h1); key(4'h2); key(4'h3); key(4'h4); key(4'h5);
      checks++; if (disp_digits !== 16'h1234) begin failures++; $display("FAIL sat_disp: got %h expected 1234", disp_digits); end
      checks++; if (entry_count !== 3'd4) begin failures++; $display("FAIL sat_count: got %0d expected 4", entry_count); end
      key(KEY_ENTER); idle(1);
      checks++; if (state_o !== 3'd3) begin failures++; $display("FAIL sat_open: got %0d expected 3", state_o); end
      checks++; if (fail_count !== 4'd0) begin failures++; $display("FAIL sat_fails: got %0d expected 0", fail_count); end
      key(KEY_LOCK);
   endtask

   task automatic test_lockout();
      for (int t = 0; t < MT; t++) begin
         key(4'h9); key(4'h9); key(4'h9); key(4'h9); key(KEY_ENTER); idle(1);
         checks++; if (fail_count !== 4'(t + 1)) begin failures++; $display("FAIL lockout_fails%0d: got %0d expected %0d", t, fail_count, t + 1); end
         checks++; if (alarm !== (t == MT - 1)) begin failures++; $display("FAIL lockout_alarm%0d: got %0b expected %0b", t, alarm, t == MT - 1); end
      end
      for (int i = 1; i < LC; i++) begin
         press(1'b1, 4'($urandom_range(0, 15)));
         checks++; if (alarm !== 1'b1 || entry_count !== 3'd0) begin failures++; $display("FAIL lockout_hold%0d: got alarm=%0b cnt=%0d expected alarm=1 cnt=0", i, alarm, entry_count); end
      end
      key(4'h1);  // arrives on the expiry edge and is dropped
      checks++; if (state_o !== 3'd0) begin failures++; $display("FAIL lockout_exit: got %0d expected 0", state_o); end
      checks++; if (fail_count !== 4'd0 || entry_count !== 3'd0) begin failures++; $display("FAIL lockout_clear: got fails=%0d cnt=%0d expected 0 0", fail_count, entry_count); end
   endtask

   task automatic test_relock();
      key(4'h1); key(4'h2); key(4'h3); key(4'h4); key(KEY_ENTER); idle(1);
      for (int i = 1; i < RC; i++) begin
         idle(1);
         checks++; if (state_o !== 3'd3) begin failures++; $display("FAIL relock_hold%0d: got %0d expected 3", i, state_o); end
      end
      idle(1);
      checks++; if (state_o !== 3'd0) begin failures++; $display("FAIL relock_expire: got %0d expected 0", state_o); end
      key(4'h1); key(4'h2); key(4'h3); key(4'h4); key(KEY_ENTER); idle(1);
      idle(7); key(4'h5); idle(RC - 1);
      checks++; if (state_o !== 3'd3) begin failures++; $display("FAIL relock_restart: got %0d expected 3", state_o); end
      idle(1);
      checks++; if (state_o !== 3'd0) begin failures++; $display("FAIL relock_restart_exp: got %0d expected 0", state_o); end
      key(4'h1); key(4'h2); key(4'h3); key(4'h4); key(KEY_ENTER); idle(1);
      idle(RC - 1); key(KEY_CHANGE);
      checks++; if (state_o !== 3'd0) begin failures++; $display("FAIL relock_drop: got %0d expected 0", state_o); end
   endtask

   task automatic test_change_code();
      key(4'h1); key(4'h2); key(4'h3); key(4'h4); key(KEY_ENTER); idle(1);
      key(KEY_CHANGE);
      checks++; if (state_o !== 3'd4 || unlocked !== 1'b1) begin failures++; $display("FAIL chg_setnew: got state=%0d unl=%0b expected 4 1", state_o, unlocked); end
      key(4'h5); key(4'h6); key(4'h7); key(4'h8); key(KEY_ENTER);
      checks++; if (state_o !== 3'd5 || disp_digits !== 16'h0) begin failures++; $display("FAIL chg_confirm: got state=%0d disp=%h expected 5 0000", state_o, disp_digits); end
      key(4'h5); key(4'h6); key(4'h7); key(4'h8); key(KEY_ENTER);
      checks++; if (state_o !== 3'd3) begin failures++; $display("FAIL chg_open: got %0d expected 3", state_o); end
      key(KEY_LOCK);
      key(4'h1); key(4'h2); key(4'h3); key(4'h4); key(KEY_ENTER); idle(1);
      checks++; if (state_o !== 3'd0 || fail_count !== 4'd1) begin failures++; $display("FAIL chg_old_code: got state=%0d fails=%0d expected 0 1", state_o, fail_count); end
      key(4'h5); key(4'h6); key(4'h7); key(4'h8); key(KEY_ENTER); idle(1);
      checks++; if (state_o !== 3'd3 || fail_count !== 4'd0) begin failures++; $display("FAIL chg_new_code: got state=%0d fails=%0d expected 3 0", state_o, fail_count); end
      key(KEY_LOCK);
   endtask

   task automatic test_random();
      logic [4:0] seq[$];
      int d[4];
      int mode;
      for (int ep = 0; ep < 40; ep++) begin
         seq.delete();
         mode = $urandom_range(0, 3);
         for (int i = 0; i < 4; i++) d[i] = $urandom_range(0, 9);
         case (mode)
            0: begin
               for (int i = 0; i < CD; i++) seq.push_back({1'b1, 4'(m_code[i])});
               seq.push_back(5'h1A);
            end
            1: begin
               for (int i = 0; i < CD; i++) seq.push_back({1'b1, 4'(d[i])});
               seq.push_back(5'h1A);
            end
            2: begin
               seq.push_back(5'h1C);
               for (int i = 0; i < CD; i++) seq.push_back({1'b1, 4'(d[i])});
               seq.push_back(5'h1A);
               if ($urandom_range(0, 3) == 0) d[0] = (d[0] + 1) % 10;
               for (int i = 0; i < CD; i++) seq.push_back({1'b1, 4'(d[i])});
               seq.push_back(5'h1A);
            end
            default: begin
               for (int i = 0; i < int'($urandom_range(1, 8)); i++) seq.push_back(5'($urandom_range(0, 31)));
            end
         endcase
         for (int i = 0; i < int'($urandom_range(0, 12)); i++) seq.push_back(5'h00);
         foreach (seq[i]) begin
            press(seq[i][4], seq[i][3:0]);
            checks++; if (state_o !== 3'(m_state)) begin failures++; $display("FAIL rnd_state c%0d: got %0d expected %0d", cyc, state_o, m_state); end
            checks++; if (unlocked !== (m_state inside {OPEN, SET_NEW, SET_CONFIRM})) begin failures++; $display("FAIL rnd_unlocked c%0d: got %0b", cyc, unlocked); end
            checks++; if (alarm !== (m_state == LOCKOUT)) begin failures++; $display("FAIL rnd_alarm c%0d: got %0b", cyc, alarm); end
            checks++; if (entry_count !== 3'(m_buf.size())) begin failures++; $display("FAIL rnd_count c%0d: got %0d expected %0d", cyc, entry_count, m_buf.size()); end
            checks++; if (disp_digits !== disp_of()) begin failures++; $display("FAIL rnd_disp c%0d: got %h expected %h", cyc, disp_digits, disp_of()); end
            checks++; if (fail_count !== 4'(m_fail)) begin failures++; $display("FAIL rnd_fails c%0d: got %0d expected %0d", cyc, fail_count, m_fail); end
         end
      end
   endtask

   task automatic test_reset_mid_confirm();
      rst = 1'b0; idle(1); rst = 1'b1;
      key(4'h1); key(4'h2); key(4'h3); key(4'h4); key(KEY_ENTER); idle(1);
      key(KEY_CHANGE); key(4'h1); key(4'h1); key(4'h1); key(4'h1); key(KEY_ENTER);
      key(4'h1); key(4'h1);
      checks++; if (state_o !== 3'd5) begin failures++; $display("FAIL mid_confirm_state: got %0d expected 5", state_o); end
      rst = 1'b0;
      idle(1);
      checks++; if (state_o !== 3'd0 || unlocked !== 1'b0 || alarm !== 1'b0) begin failures++; $display("FAIL mid_reset_state: got state=%0d unl=%0b alarm=%0b expected 0 0 0", state_o, unlocked, alarm); end
      checks++; if (entry_count !== 3'd0 || disp_digits !== 16'h0 || fail_count !== 4'd0) begin failures++; $display("FAIL mid_reset_regs: got cnt=%0d disp=%h fails=%0d expected 0", entry_count, disp_digits, fail_count); end
      rst = 1'b1;
      key(4'h1); key(4'h1); key(4'h1); key(4'h1); key(KEY_ENTER); idle(1);
      checks++; if (state_o !== 3'd0 || fail_count !== 4'd1) begin failures++; $display("FAIL mid_code_kept_old: got state=%0d fails=%0d expected 0 1", state_o, fail_count); end
      key(4'h1); key(4'h2); key(4'h3); key(4'h4); key(KEY_ENTER); idle(1);
      checks++; if (state_o !== 3'd3) begin failures++; $display("FAIL mid_default_code: got %0d expected 3", state_o); end
   endtask

   initial begin
      test_reset();
      test_unlock();
      test_short_and_saturate();
      test_lockout();
      test_relock();
      test_change_code();
      test_random();
      test_reset_mid_confirm();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
